branch_target_predictor: RTL and testbench

- Fetch-side branch predictor: direct-mapped BTB plus a 2-bit saturating counter per entry.
- Each cycle, fetch receives a next-PC prediction and a predicted direction for the current fetch PC. The predicted direction travels with the branch and is later compared against the resolved outcome by the branch functional unit.
- Trained from that unit's resolution outputs: update_btb, update_pc, branch_target, branch_outcome, misprediction.
- Sits directly downstream of branch resolution (consumer) and upstream of fetch.

---
 rtl/branch_target_predictor_if.sv | 25 ++
 rtl/branch_target_predictor.sv | 106 ++++++++++
 tb/tb_branch_target_predictor.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/branch_target_predictor_if.sv
// Fetch/resolution bundle between the branch unit, the predictor and fetch.
// The master drives fetch PCs and resolutions; the slave returns predictions and perf counts.
interface branch_target_predictor_if;
    logic [31:0] fetch_pc;
    logic        predict_hit;
    logic        predict_taken;
    logic [31:0] predict_pc;
    logic        update_btb;
    logic [31:0] update_pc;
    logic [31:0] branch_target;
    logic        branch_outcome;
    logic        misprediction;
    logic [31:0] mispredict_count;
    logic [31:0] branch_count;

    modport master (
        output fetch_pc, update_btb, update_pc, branch_target, branch_outcome, misprediction,
        input  predict_hit, predict_taken, predict_pc, mispredict_count, branch_count
    );

    modport slave (
        input  fetch_pc, update_btb, update_pc, branch_target, branch_outcome, misprediction,
        output predict_hit, predict_taken, predict_pc, mispredict_count, branch_count
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Prediction is combinational from pre-update state; training lands on the next rising edge.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input logic CLK,
    input logic RST,
    branch_target_predictor_if.slave bus
);
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;

    assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
    assign fetch_tag = bus.fetch_pc[31:IDX_W+2];
    assign upd_idx   = bus.update_pc[IDX_W+1:2];
    assign upd_tag   = bus.update_pc[31:IDX_W+2];

    // Byte-offset bits carry no information for word-aligned fetch.
    logic unused_pc_low;
    assign unused_pc_low = ^{bus.fetch_pc[1:0], bus.update_pc[1:0]};

    logic             valid_arr  [ENTRIES];
    logic [TAG_W-1:0] tag_arr    [ENTRIES];
    logic [31:0]      target_arr [ENTRIES];
    logic [1:0]       ctr_arr    [ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [31:0]      target_reg;
            logic [1:0]       ctr_reg;
            logic             sel;
            logic             upd_hit;

            assign sel     = bus.update_btb && (upd_idx == IDX_W'(gi));
            assign upd_hit = valid_reg && (tag_reg == upd_tag);

            always_ff @(posedge CLK) begin
                if (RST) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= CTR_WNT;
                end else if (sel) begin
                    if (upd_hit) begin
                        if (bus.branch_outcome) begin
                            ctr_reg    <= (ctr_reg == CTR_ST) ? CTR_ST : ctr_reg + 2'd1;
                            target_reg <= bus.branch_target;
                        end else begin
                            ctr_reg <= (ctr_reg == CTR_SNT) ? CTR_SNT : ctr_reg - 2'd1;
                        end
                    end else if (bus.branch_outcome) begin
                        // Taken miss evicts whatever occupies this slot.
                        valid_reg  <= 1'b1;
                        tag_reg    <= upd_tag;
                        target_reg <= bus.branch_target;
                        ctr_reg    <= CTR_WT;
                    end
                end
            end

            assign valid_arr[gi]  = valid_reg;
            assign tag_arr[gi]    = tag_reg;
            assign target_arr[gi] = target_reg;
            assign ctr_arr[gi]    = ctr_reg;
        end
    endgenerate

    logic hit;
    logic taken;

    assign hit               = valid_arr[fetch_idx] && (tag_arr[fetch_idx] == fetch_tag);
    assign taken             = hit && ctr_arr[fetch_idx][1];
    assign bus.predict_hit   = hit;
    assign bus.predict_taken = taken;
    assign bus.predict_pc    = taken ? target_arr[fetch_idx] : bus.fetch_pc + 32'd4;

    logic [31:0] branch_count_reg;
    logic [31:0] mispredict_count_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else if (bus.update_btb) begin
            if (branch_count_reg != 32'hFFFF_FFFF)
                branch_count_reg <= branch_count_reg + 32'd1;
            if (bus.misprediction && (mispredict_count_reg != 32'hFFFF_FFFF))
                mispredict_count_reg <= mispredict_count_reg + 32'd1;
        end
    end

    assign bus.branch_count     = branch_count_reg;
    assign bus.mispredict_count = mispredict_count_reg;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: stimulus pushes expected predictions from a table-level model,
// a negedge monitor pops and compares against the predictor outputs.
module tb_branch_target_predictor;
    localparam int ENTRIES = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    branch_target_predictor_if bus ();

    branch_target_predictor #(.ENTRIES(ENTRIES)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] fetch;
        logic        hit;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] mcount;
        logic [31:0] bcount;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    bit   obs_valid = 1'b0;

    // Reference model: a table of branch records keyed by slot number.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    int unsigned m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    longint      m_bcount;
    longint      m_mcount;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return int'(pc) / (ENTRIES * 4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
        end
        m_bcount = 0;
        m_mcount = 0;
    endtask

    task automatic cycle(input logic [31:0] fpc, input bit upd, input logic [31:0] upc,
                         input logic [31:0] tgt, input bit outcome, input bit mis);
        exp_t e;
        int   s;
        bit   h;
        @(posedge CLK);
        #1;
        bus.fetch_pc       = fpc;
        bus.update_btb     = upd;
        bus.update_pc      = upc;
        bus.branch_target  = tgt;
        bus.branch_outcome = outcome;
        bus.misprediction  = mis;
        s = slot_of(fpc);
        e.fetch  = fpc;
        e.hit    = m_valid[s] && (m_tag[s] == tag_of(fpc));
        e.taken  = e.hit && (m_ctr[s] >= 2);
        e.pc     = e.taken ? m_target[s] : fpc + 32'd4;
        e.mcount = 32'(m_mcount);
        e.bcount = 32'(m_bcount);
        sb.push_back(e);
        obs_valid = 1'b1;
        if (upd) begin
            s = slot_of(upc);
            h = m_valid[s] && (m_tag[s] == tag_of(upc));
            if (h && outcome) begin
                m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                m_target[s] = tgt;
            end else if (h) begin
                m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
            end else if (outcome) begin
                m_valid[s] = 1'b1; m_tag[s] = tag_of(upc); m_target[s] = tgt; m_ctr[s] = 2;
            end
            if (m_bcount < 64'hFFFF_FFFF) m_bcount++;
            if (mis && m_mcount < 64'hFFFF_FFFF) m_mcount++;
        end
    endtask

    task automatic do_reset(input bit with_update);
        @(posedge CLK);
        #1;
        obs_valid          = 1'b0;
        RST                = 1'b1;
        bus.update_btb     = with_update;
        bus.update_pc      = 32'h100;
        bus.branch_target  = 32'h200;
        bus.branch_outcome = 1'b1;
        bus.misprediction  = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        RST            = 1'b0;
        bus.update_btb = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s txn=%0d got=%h expected=%h", name, txn, act, exp_v);
        end
    endtask

    // Monitor: the predictor presents a response every observed cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (obs_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty txn=%0d got=output expected=queued_entry", txn);
                end else begin
                    e = sb.pop_front();
                    chk("fetch_pc_echo", bus.fetch_pc, e.fetch);
                    chk("predict_hit", 32'(bus.predict_hit), 32'(e.hit));
                    chk("predict_taken", 32'(bus.predict_taken), 32'(e.taken));
                    chk("predict_pc", bus.predict_pc, e.pc);
                    chk("mispredict_count", bus.mispredict_count, e.mcount);
                    chk("branch_count", bus.branch_count, e.bcount);
                    $display("txn %0d fetch=%h hit=%0b taken=%0b npc=%h mcnt=%0d bcnt=%0d",
                             txn, bus.fetch_pc, bus.predict_hit, bus.predict_taken,
                             bus.predict_pc, bus.mispredict_count, bus.branch_count);
                    txn++;
                end
            end
        end
    end

    initial begin
        logic [31:0] fpc, upc;
        int wait_cycles;
        bus.fetch_pc = 32'h100; bus.update_btb = 1'b1; bus.update_pc = 32'h100;
        bus.branch_target = 32'h200; bus.branch_outcome = 1'b1; bus.misprediction = 1'b1;
        model_reset();
        do_reset(1'b1);

        cycle(32'h100, 0, 0, 0, 0, 0);
        cycle(32'h100, 1, 32'h100, 32'h200, 1, 1);
        cycle(32'h100, 1, 32'h100, 32'h999, 0, 1);
        cycle(32'h100, 1, 32'h100, 32'h999, 0, 0);
        cycle(32'h100, 1, 32'h100, 32'h999, 0, 0);
        cycle(32'h100, 1, 32'h100, 32'h200, 1, 1);
        cycle(32'h100, 1, 32'h100, 32'h200, 1, 1);
        cycle(32'h100, 1, 32'h300, 32'h500, 0, 0);
        cycle(32'h300, 1, 32'h140, 32'h400, 1, 0);
        cycle(32'h100, 0, 0, 0, 0, 0);
        cycle(32'h140, 1, 32'h100, 32'h600, 0, 0);
        cycle(32'h140, 0, 0, 0, 0, 0);
        do_reset(1'b0);
        cycle(32'h140, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            fpc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
            upc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
            cycle(fpc, ($urandom_range(0, 9) < 7), upc, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
        end

        do_reset(1'b1);
        cycle(32'h100, 0, 0, 0, 0, 0);

        @(posedge CLK);
        #1;
        obs_valid = 1'b0;
        bus.update_btb = 1'b0;
        wait_cycles = 0;
        while (sb.size() != 0 && wait_cycles < 20) begin
            @(posedge CLK);
            wait_cycles++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain got=%0d expected=0 pending entries", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
